// File: rtl/hilo_divider.sv
// Multi-cycle 32-bit unsigned restoring divider with private HI (remainder) / LO (quotient)
// registers, driven by the same funct-code bus as the ALU.
module hilo_divider (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] dataA,
   input  logic [31:0] dataB,
   input  logic [5:0]  Signal,
   output logic [31:0] dataOut,
   output logic        busy
);

   localparam logic [5:0] DIVU = 6'b011011;
   localparam logic [5:0] MFHI = 6'b010000;
   localparam logic [5:0] MFLO = 6'b010010;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t      r_state;
   logic        r_busy;
   logic [5:0]  r_cnt;
   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_div;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic [32:0] w_trial;
   logic [32:0] w_diff;
   logic [31:0] w_rem_next;
   logic [31:0] w_quo_next;

   // The partial remainder is always below the divisor, so its 33rd bit is
   // always zero and only 32 bits are stored.
   always_comb begin
      w_trial    = {r_rem, r_quo[31]};
      w_diff     = w_trial - {1'b0, r_div};
      w_rem_next = w_trial[31:0];
      w_quo_next = {r_quo[30:0], 1'b0};
      if (!w_diff[32]) begin
         w_rem_next = w_diff[31:0];
         w_quo_next = {r_quo[30:0], 1'b1};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_div   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (Signal == DIVU) begin
                  r_rem   <= '0;
                  r_quo   <= dataA;
                  r_div   <= dataB;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_rem <= w_rem_next;
               r_quo <= w_quo_next;
               r_cnt <= r_cnt + 6'd1;
               if (r_cnt == 6'd31) begin
                  r_hi    <= w_rem_next;
                  r_lo    <= w_quo_next;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      dataOut = '0;
      case (Signal)
         MFHI:    dataOut = r_hi;
         MFLO:    dataOut = r_lo;
         default: dataOut = '0;
      endcase
   end

   assign busy = r_busy;

endmodule

// File: tb/tb_hilo_divider.sv
// Bench for hilo_divider: vector table through a result scoreboard, plus hand-written
// sequences for mid-run interference, back-to-back DIVU and asynchronous abort.
module tb_hilo_divider;

   localparam logic [5:0] DIVU = 6'b011011;
   localparam logic [5:0] MFHI = 6'b010000;
   localparam logic [5:0] MFLO = 6'b010010;
   localparam logic [5:0] NOP  = 6'b000000;

   logic        clk;
   logic        reset;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic [5:0]  Signal;
   logic [31:0] dataOut;
   logic        busy;

   hilo_divider dut (
      .clk     (clk),
      .reset   (reset),
      .dataA   (dataA),
      .dataB   (dataB),
      .Signal  (Signal),
      .dataOut (dataOut),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
   } vec_t;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      string       name;
   } exp_t;

   vec_t vecs [9];
   exp_t sb [$];
   int   n_checks;
   int   n_fail;
   int   edges;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_div(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      dataA  = a;
      dataB  = b;
      Signal = DIVU;
      @(posedge clk);
      #1;
      check("busy_after_start", {31'd0, busy}, 32'd1);
   endtask

   // Counts edges after the start edge until busy drops, bounded.
   task automatic wait_done(output int n);
      n = 0;
      while (busy && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic compare_result();
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         @(negedge clk);
         Signal = MFLO;
         #1 check({e.name, "_LO"}, dataOut, e.lo);
         Signal = MFHI;
         #1 check({e.name, "_HI"}, dataOut, e.hi);
         Signal = NOP;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      dataA    = '0;
      dataB    = '0;
      Signal   = NOP;

      vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2};
      vecs[1] = '{32'hFFFFFFFF,   32'h00000002,   32'h7FFFFFFF,   32'd1};
      vecs[2] = '{32'd12345,      32'd0,          32'hFFFFFFFF,   32'd12345};
      vecs[3] = '{32'd0,          32'd0,          32'hFFFFFFFF,   32'd0};
      vecs[4] = '{32'd7,          32'd100,        32'd0,          32'd7};
      vecs[5] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0};
      vecs[6] = '{32'hDEADBEEF,   32'h00000010,   32'h0DEADBEE,   32'hF};
      vecs[7] = '{32'd0,          32'd5,          32'd0,          32'd0};
      vecs[8] = '{32'd100,        32'd7,          32'd14,         32'd2};

      #2;
      check("reset_busy", {31'd0, busy}, 32'd0);
      Signal = MFHI;
      #1 check("reset_MFHI", dataOut, 32'd0);
      Signal = MFLO;
      #1 check("reset_MFLO", dataOut, 32'd0);
      Signal = NOP;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         start_div(vecs[i].a, vecs[i].b);
         sb.push_back('{vecs[i].lo, vecs[i].hi, $sformatf("vec%0d", i)});
         @(negedge clk);
         Signal = NOP;
         wait_done(edges);
         check($sformatf("vec%0d_busy_edges", i), edges, 32'd32);
         compare_result();
      end

      // ALU funct codes never drive the output.
      @(negedge clk);
      Signal = 6'd32;
      #1 check("alu_code_32", dataOut, 32'd0);
      Signal = 6'd42;
      #1 check("alu_code_42", dataOut, 32'd0);
      Signal = NOP;

      // 50/5 with a DIVU, operand change and MFLO landing mid-run.
      start_div(32'd50, 32'd5);
      sb.push_back('{32'd10, 32'd0, "interfere"});
      edges = 0;
      while (busy && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
         if (edges == 1) Signal = NOP;
         if (edges == 10) begin
            Signal = DIVU;
            dataA  = 32'd9;
            dataB  = 32'd3;
         end
         if (edges == 11) Signal = NOP;
         if (edges == 20) begin
            Signal = MFLO;
            #1 check("mflo_during_run", dataOut, 32'd14);
            Signal = NOP;
         end
      end
      check("interfere_busy_edges", edges, 32'd32);
      compare_result();

      // DIVU held high: refused on the completion edge, accepted on the next.
      start_div(32'd20, 32'd3);
      sb.push_back('{32'd6, 32'd2, "held_divu"});
      wait_done(edges);
      check("held_first_edges", edges, 32'd32);
      check("held_busy_low_after_E32", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1 check("held_restart_at_E33", {31'd0, busy}, 32'd1);
      Signal = NOP;
      wait_done(edges);
      check("held_second_edges", edges, 32'd32);
      compare_result();

      // Asynchronous abort partway through a run.
      start_div(32'd100, 32'd7);
      @(negedge clk);
      Signal = NOP;
      edges = 1;
      while (edges < 16) begin
         @(posedge clk);
         edges++;
      end
      #1 reset = 1'b1;
      #1 check("abort_busy", {31'd0, busy}, 32'd0);
      Signal = MFLO;
      #1 check("abort_LO", dataOut, 32'd0);
      Signal = MFHI;
      #1 check("abort_HI", dataOut, 32'd0);
      Signal = NOP;
      @(negedge clk);
      reset = 1'b0;
      start_div(32'd100, 32'd7);
      sb.push_back('{32'd14, 32'd2, "after_abort"});
      @(negedge clk);
      Signal = NOP;
      wait_done(edges);
      check("after_abort_edges", edges, 32'd32);
      compare_result();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
